br_dump: RTL

//   Sequential read-out engine for the 32x32 register file (br). On start it walks a

---
 rtl/br_dump.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/br_dump.sv
// -----------------------------------------------------------------------------
// br_dump -- sequential read-out engine for the 32x32 register file (br).
//
// On start it walks a window of register addresses through one br read port
// and streams each word out on a valid/ready interface, tagged with the
// source address and a last-beat flag.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request a dump (sampled only while idle)
//   start_addr  first register to read
//   count       number of registers to read, 0..2**ADDR_W
//   abort       synchronous cancel of a dump in progress
//   rr_addr     br read-port address (registered)
//   rd_data     br read data for rr_addr (combinational, same cycle)
//   out_valid   out_data/out_addr/out_last hold a beat
//   out_ready   sink accepts the beat when out_valid && out_ready at an edge
//   out_data    captured register word
//   out_addr    address the word came from
//   out_last    beat is the final beat of the dump
//   busy        high whenever the engine is not idle
//   done        one-cycle pulse when a dump completes normally
// -----------------------------------------------------------------------------
module br_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              abort,
  output logic [ADDR_W-1:0] rr_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   REM_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   REM_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  // Next register address; the natural ADDR_W-bit overflow gives the
  // wrap from the top entry back to entry 0.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    addr_inc = a + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

  state_t              state_r,     state_nxt_s;
  logic [ADDR_W-1:0]   cur_r,       cur_nxt_s;
  logic [ADDR_W:0]     rem_r,       rem_nxt_s;
  logic [ADDR_W-1:0]   rr_addr_r,   rr_addr_nxt_s;
  logic [DATA_W-1:0]   out_data_r,  out_data_nxt_s;
  logic [ADDR_W-1:0]   out_addr_r,  out_addr_nxt_s;
  logic                out_valid_r, out_valid_nxt_s;
  logic                out_last_r,  out_last_nxt_s;
  logic                busy_r,      busy_nxt_s;
  logic                done_r,      done_nxt_s;

  logic                handshake_s;
  logic                last_beat_s;
  logic                start_ok_s;

  assign handshake_s = out_valid_r && out_ready;
  assign last_beat_s = (rem_r == REM_ONE);
  assign start_ok_s  = (count != REM_ZERO);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; abort outranks every other event once a dump is live.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = start_ok_s ? ST_FETCH : ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (handshake_s) begin
          state_nxt_s = last_beat_s ? ST_DONE : ST_FETCH;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the datapath and of every registered output.
  always_comb begin
    cur_nxt_s       = cur_r;
    rem_nxt_s       = rem_r;
    rr_addr_nxt_s   = rr_addr_r;
    out_data_nxt_s  = out_data_r;
    out_addr_nxt_s  = out_addr_r;
    out_valid_nxt_s = out_valid_r;
    out_last_nxt_s  = out_last_r;
    case (state_r)
      ST_IDLE: begin
        if (start && start_ok_s) begin
          cur_nxt_s     = start_addr;
          rem_nxt_s     = count;
          rr_addr_nxt_s = start_addr;
        end else begin
          cur_nxt_s     = cur_r;
          rem_nxt_s     = rem_r;
        end
        out_valid_nxt_s = 1'b0;
        out_last_nxt_s  = 1'b0;
      end
      ST_FETCH: begin
        if (abort) begin
          out_valid_nxt_s = 1'b0;
          out_last_nxt_s  = 1'b0;
        end else begin
          // rr_addr has been stable for this whole cycle, so rd_data is
          // the word at cur; freezing it here makes the beat immune to
          // later register-file writes.
          out_data_nxt_s  = rd_data;
          out_addr_nxt_s  = cur_r;
          out_last_nxt_s  = last_beat_s;
          out_valid_nxt_s = 1'b1;
        end
      end
      ST_SEND: begin
        if (abort) begin
          out_valid_nxt_s = 1'b0;
          out_last_nxt_s  = 1'b0;
        end else if (handshake_s) begin
          out_valid_nxt_s = 1'b0;
          out_last_nxt_s  = 1'b0;
          if (last_beat_s) begin
            rem_nxt_s = REM_ZERO;
          end else begin
            cur_nxt_s     = addr_inc(cur_r);
            rem_nxt_s     = rem_r - REM_ONE;
            rr_addr_nxt_s = addr_inc(cur_r);
          end
        end else begin
          out_valid_nxt_s = out_valid_r;
          out_last_nxt_s  = out_last_r;
        end
      end
      ST_DONE: begin
        out_valid_nxt_s = 1'b0;
        out_last_nxt_s  = 1'b0;
      end
      default: begin
        out_valid_nxt_s = 1'b0;
        out_last_nxt_s  = 1'b0;
      end
    endcase
    // busy/done are registered copies of where the FSM is heading, so
    // they line up exactly with the state they describe.
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = (state_nxt_s == ST_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_r       <= ADDR_ZERO;
      rem_r       <= REM_ZERO;
      rr_addr_r   <= ADDR_ZERO;
      out_data_r  <= DATA_ZERO;
      out_addr_r  <= ADDR_ZERO;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      cur_r       <= cur_nxt_s;
      rem_r       <= rem_nxt_s;
      rr_addr_r   <= rr_addr_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_addr_r  <= out_addr_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_last_r  <= out_last_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  assign rr_addr   = rr_addr_r;
  assign out_data  = out_data_r;
  assign out_addr  = out_addr_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
